mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/tartaruga_pkg.sv | 70 +++++++
 rtl/mem_stage_if.sv | 36 +++
 rtl/mem_stage_align.sv | 47 ++++
 rtl/mem_stage.sv | 146 ++++++++++++++
 tb/tb_mem_stage.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/tartaruga_pkg.sv
// Shared types for the memory stage: instruction fields, pipeline payloads,
// FSM states and access-size helpers.
package tartaruga_pkg;

    typedef logic [4:0] reg_addr_t;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } mem_state_t;

    typedef struct packed {
        reg_addr_t rd;
        reg_addr_t rs1;
        reg_addr_t rs2;
        logic      reg_write;
        logic      is_load;
        logic      is_store;
        mem_size_t mem_size;
        logic      mem_unsigned;
    } instr_t;

    localparam instr_t NOP_INSTR = '{
        rd:           5'd0,
        rs1:          5'd0,
        rs2:          5'd0,
        reg_write:    1'b0,
        is_load:      1'b0,
        is_store:     1'b0,
        mem_size:     BYTE,
        mem_unsigned: 1'b0
    };

    typedef struct packed {
        logic        valid;
        instr_t      instr;
        logic [31:0] result;
        logic [31:0] data_rs2;
        logic        branch_taken;
    } exe_to_mem_t;

    typedef struct packed {
        logic        valid;
        instr_t      instr;
        logic [31:0] result;
        logic        misaligned;
    } mem_to_wb_t;

    function automatic logic is_mem_op(input instr_t instr);
        return instr.is_load || instr.is_store;
    endfunction

    function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] offset);
        logic mis;
        case (size)
            HALF:    mis = offset[0];
            WORD:    mis = |offset;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/response bus between the memory stage (master) and
// the data memory (slave).
interface mem_stage_if;

    logic        dmem_req_valid_o;
    logic        dmem_req_ready_i;
    logic [31:0] dmem_req_addr_o;
    logic        dmem_req_we_o;
    logic [31:0] dmem_req_wdata_o;
    logic [3:0]  dmem_req_be_o;
    logic        dmem_rsp_valid_i;
    logic [31:0] dmem_rsp_rdata_i;

    modport master (
        output dmem_req_valid_o,
        output dmem_req_addr_o,
        output dmem_req_we_o,
        output dmem_req_wdata_o,
        output dmem_req_be_o,
        input  dmem_req_ready_i,
        input  dmem_rsp_valid_i,
        input  dmem_rsp_rdata_i
    );

    modport slave (
        input  dmem_req_valid_o,
        input  dmem_req_addr_o,
        input  dmem_req_we_o,
        input  dmem_req_wdata_o,
        input  dmem_req_be_o,
        output dmem_req_ready_i,
        output dmem_rsp_valid_i,
        output dmem_rsp_rdata_i
    );

endinterface

// File: rtl/mem_stage_align.sv
// Byte-lane alignment shared by stores (enables + lane replication) and
// loads (shift down + sign/zero extension).
module mem_align
    import tartaruga_pkg::*;
(
    input  mem_size_t   size_i,
    input  logic        unsigned_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] load_word_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_data_o,
    output logic        misaligned_o
);

    logic [31:0] shifted;

    assign shifted      = load_word_i >> {offset_i, 3'b000};
    assign misaligned_o = is_misaligned(size_i, offset_i);

    always_comb begin
        case (size_i)
            BYTE:    be_o = 4'b0001 << offset_i;
            HALF:    be_o = 4'b0011 << {offset_i[1], 1'b0};
            default: be_o = 4'b1111;
        endcase
    end

    // Each lane carries the low byte (byte), the matching half byte (half)
    // or its own byte (word), so the memory only has to honour be_o.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign wdata_o[8*gi +: 8] =
            (size_i == BYTE) ? store_data_i[7:0] :
            (size_i == HALF) ? store_data_i[8*(gi%2) +: 8] :
                               store_data_i[8*gi +: 8];
    end

    always_comb begin
        case (size_i)
            BYTE:    load_data_o = {{24{~unsigned_i & shifted[7]}},  shifted[7:0]};
            HALF:    load_data_o = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
            default: load_data_o = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: one outstanding data-memory access at a time,
// stalling upstream until the access completes.
module mem_stage
    import tartaruga_pkg::*;
(
    input  logic          clk_i,
    input  logic          rstn_i,
    input  exe_to_mem_t   exe_to_mem_i,
    input  reg_addr_t     rs1_decoded_i,
    input  reg_addr_t     rs2_decoded_i,
    mem_stage_if.master   dmem,
    output mem_to_wb_t    mem_to_wb_o,
    output logic          stall_o,
    output logic          hazard_on_mem_o
);

    localparam exe_to_mem_t STAGE_RESET = '{
        valid:        1'b0,
        instr:        NOP_INSTR,
        result:       32'd0,
        data_rs2:     32'd0,
        branch_taken: 1'b0
    };

    localparam mem_to_wb_t WB_RESET = '{
        valid:      1'b0,
        instr:      NOP_INSTR,
        result:     32'd0,
        misaligned: 1'b0
    };

    mem_state_t  state_q, state_d;
    exe_to_mem_t stage_q, stage_d;
    mem_to_wb_t  wb_q, wb_d;

    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] load_data;
    logic        stage_misaligned;
    logic        incoming_access;
    logic        unused_bits;

    mem_align u_align (
        .size_i       (stage_q.instr.mem_size),
        .unsigned_i   (stage_q.instr.mem_unsigned),
        .offset_i     (stage_q.result[1:0]),
        .store_data_i (stage_q.data_rs2),
        .load_word_i  (dmem.dmem_rsp_rdata_i),
        .be_o         (lane_be),
        .wdata_o      (lane_wdata),
        .load_data_o  (load_data),
        .misaligned_o (stage_misaligned)
    );

    assign unused_bits = stage_q.branch_taken;

    assign incoming_access = exe_to_mem_i.valid && is_mem_op(exe_to_mem_i.instr) &&
                             !is_misaligned(exe_to_mem_i.instr.mem_size, exe_to_mem_i.result[1:0]);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A capture decides the next state directly, so an aligned access
    // enters REQ in the same cycle the stage register takes it.
    always_comb begin
        state_d = state_q;
        if (!stall_o) begin
            state_d = incoming_access ? REQ : IDLE;
        end else if (state_q == REQ && dmem.dmem_req_ready_i) begin
            state_d = WAIT;
        end
    end

    always_comb begin
        stall_o = 1'b0;
        case (state_q)
            REQ:     stall_o = !(dmem.dmem_req_ready_i && stage_q.instr.is_store);
            WAIT:    stall_o = !dmem.dmem_rsp_valid_i;
            default: stall_o = 1'b0;
        endcase
    end

    always_comb begin
        dmem.dmem_req_valid_o = (state_q == REQ);
        dmem.dmem_req_addr_o  = {stage_q.result[31:2], 2'b00};
        dmem.dmem_req_we_o    = stage_q.instr.is_store;
        dmem.dmem_req_wdata_o = lane_wdata;
        dmem.dmem_req_be_o    = lane_be;
    end

    always_comb begin
        hazard_on_mem_o = (state_q != IDLE) && stage_q.valid && stage_q.instr.is_load &&
                          (stage_q.instr.rd != 5'd0) &&
                          ((rs1_decoded_i == stage_q.instr.rd) || (rs2_decoded_i == stage_q.instr.rd));
    end

    always_comb begin
        stage_d = stall_o ? stage_q : exe_to_mem_i;

        wb_d            = WB_RESET;
        wb_d.instr      = stage_q.instr;
        wb_d.result     = stage_q.result;
        case (state_q)
            IDLE: begin
                // Only non-memory or misaligned instructions sit here in IDLE.
                if (stage_q.valid) begin
                    wb_d.valid = 1'b1;
                    if (is_mem_op(stage_q.instr) && stage_misaligned) begin
                        wb_d.misaligned      = 1'b1;
                        wb_d.instr.reg_write = 1'b0;
                    end
                end
            end
            REQ: begin
                if (dmem.dmem_req_ready_i && stage_q.instr.is_store) begin
                    wb_d.valid = 1'b1;
                end
            end
            WAIT: begin
                if (dmem.dmem_rsp_valid_i) begin
                    wb_d.valid  = 1'b1;
                    wb_d.result = load_data;
                end
            end
            default: wb_d.valid = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            stage_q <= STAGE_RESET;
            wb_q    <= WB_RESET;
        end else begin
            stage_q <= stage_d;
            wb_q    <= wb_d;
        end
    end

    assign mem_to_wb_o = wb_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, stores, loads, misaligned
// access, load-use hazard and reset in the middle of a load.
module tb_mem_stage;
    import tartaruga_pkg::*;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    exe_to_mem_t exe;
    reg_addr_t   rs1_dec;
    reg_addr_t   rs2_dec;
    mem_to_wb_t  wb;
    logic        stall;
    logic        hazard;

    int tests_run    = 0;
    int tests_failed = 0;

    mem_stage_if dmem_bus ();

    mem_stage dut (
        .clk_i           (clk_i),
        .rstn_i          (rstn_i),
        .exe_to_mem_i    (exe),
        .rs1_decoded_i   (rs1_dec),
        .rs2_decoded_i   (rs2_dec),
        .dmem            (dmem_bus),
        .mem_to_wb_o     (wb),
        .stall_o         (stall),
        .hazard_on_mem_o (hazard)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic exe_to_mem_t mk(input logic ld, input logic st, input mem_size_t sz,
                                       input logic uns, input reg_addr_t rd,
                                       input logic [31:0] res, input logic [31:0] rs2);
        exe_to_mem_t e;
        e                    = '0;
        e.valid              = 1'b1;
        e.instr              = NOP_INSTR;
        e.instr.rd           = rd;
        e.instr.reg_write    = !st;
        e.instr.is_load      = ld;
        e.instr.is_store     = st;
        e.instr.mem_size     = sz;
        e.instr.mem_unsigned = uns;
        e.result             = res;
        e.data_rs2           = rs2;
        return e;
    endfunction

    task automatic do_store(input string name, input mem_size_t sz, input logic [31:0] addr,
                            input logic [31:0] rs2, input int delay, input logic [31:0] exp_addr,
                            input logic [3:0] exp_be, input logic [31:0] exp_wd);
        exe = mk(1'b0, 1'b1, sz, 1'b0, 5'd0, addr, rs2);
        dmem_bus.dmem_req_ready_i = 1'b0;
        tick();
        for (int i = 0; i < delay; i++) begin
            @(negedge clk_i);
            chk({name, "_hold_valid"}, dmem_bus.dmem_req_valid_o, 1);
            chk({name, "_hold_addr"},  dmem_bus.dmem_req_addr_o, exp_addr);
            chk({name, "_hold_be"},    dmem_bus.dmem_req_be_o, exp_be);
            chk({name, "_hold_wdata"}, dmem_bus.dmem_req_wdata_o, exp_wd);
            chk({name, "_hold_stall"}, stall, 1);
            chk({name, "_hold_wb"},    wb.valid, 0);
            tick();
        end
        dmem_bus.dmem_req_ready_i = 1'b1;
        exe = '0;
        @(negedge clk_i);
        chk({name, "_acc_stall"}, stall, 0);
        chk({name, "_acc_valid"}, dmem_bus.dmem_req_valid_o, 1);
        chk({name, "_acc_we"},    dmem_bus.dmem_req_we_o, 1);
        chk({name, "_acc_be"},    dmem_bus.dmem_req_be_o, exp_be);
        chk({name, "_acc_wdata"}, dmem_bus.dmem_req_wdata_o, exp_wd);
        tick();
        dmem_bus.dmem_req_ready_i = 1'b0;
        @(negedge clk_i);
        chk({name, "_wb_valid"}, wb.valid, 1);
        chk({name, "_wb_mis"},   wb.misaligned, 0);
        chk({name, "_idle_req"}, dmem_bus.dmem_req_valid_o, 0);
        tick();
        @(negedge clk_i);
        chk({name, "_wb_once"}, wb.valid, 0);
        $display("[TB] %s addr=0x%08h be=%b wdata=0x%08h", name, addr, dmem_bus.dmem_req_be_o, exp_wd);
    endtask

    task automatic do_load(input string name, input mem_size_t sz, input logic uns,
                           input reg_addr_t rd, input logic [31:0] addr, input logic [31:0] rdata,
                           input logic [3:0] exp_be, input logic [31:0] exp_res, input logic exp_haz);
        exe = mk(1'b1, 1'b0, sz, uns, rd, addr, 32'h0);
        dmem_bus.dmem_req_ready_i = 1'b1;
        tick();
        @(negedge clk_i);
        chk({name, "_req_valid"}, dmem_bus.dmem_req_valid_o, 1);
        chk({name, "_req_we"},    dmem_bus.dmem_req_we_o, 0);
        chk({name, "_req_be"},    dmem_bus.dmem_req_be_o, exp_be);
        chk({name, "_req_addr"},  dmem_bus.dmem_req_addr_o, {addr[31:2], 2'b00});
        chk({name, "_req_stall"}, stall, 1);
        tick();
        dmem_bus.dmem_req_ready_i = 1'b0;
        @(negedge clk_i);
        chk({name, "_wait_stall"}, stall, 1);
        chk({name, "_wait_req"},   dmem_bus.dmem_req_valid_o, 0);
        chk({name, "_wait_wb"},    wb.valid, 0);
        chk({name, "_wait_haz"},   hazard, exp_haz);
        tick();
        dmem_bus.dmem_rsp_valid_i = 1'b1;
        dmem_bus.dmem_rsp_rdata_i = rdata;
        exe = '0;
        @(negedge clk_i);
        chk({name, "_rsp_stall"}, stall, 0);
        tick();
        dmem_bus.dmem_rsp_valid_i = 1'b0;
        @(negedge clk_i);
        chk({name, "_wb_valid"},  wb.valid, 1);
        chk({name, "_wb_result"}, wb.result, exp_res);
        tick();
        @(negedge clk_i);
        chk({name, "_wb_once"}, wb.valid, 0);
        $display("[TB] %s addr=0x%08h rdata=0x%08h result=0x%08h", name, addr, rdata, exp_res);
    endtask

    initial begin
        rstn_i  = 1'b0;
        exe     = '0;
        rs1_dec = 5'd5;
        rs2_dec = 5'd9;
        dmem_bus.dmem_req_ready_i = 1'b0;
        dmem_bus.dmem_rsp_valid_i = 1'b0;
        dmem_bus.dmem_rsp_rdata_i = 32'h0;

        repeat (2) tick();
        @(negedge clk_i);
        chk("rst_stall",  stall, 0);
        chk("rst_req",    dmem_bus.dmem_req_valid_o, 0);
        chk("rst_wb",     wb.valid, 0);
        chk("rst_hazard", hazard, 0);
        rstn_i = 1'b1;
        tick();

        // ALU result passes straight through in the following cycle
        exe = mk(1'b0, 1'b0, WORD, 1'b0, 5'd3, 32'h0000_1234, 32'h0);
        tick();
        exe = '0;
        @(negedge clk_i);
        chk("add_c0_wb",  wb.valid, 0);
        chk("add_c0_req", dmem_bus.dmem_req_valid_o, 0);
        chk("add_c0_stall", stall, 0);
        tick();
        @(negedge clk_i);
        chk("add_c1_wb",     wb.valid, 1);
        chk("add_c1_result", wb.result, 32'h0000_1234);
        chk("add_c1_req",    dmem_bus.dmem_req_valid_o, 0);
        tick();
        @(negedge clk_i);
        chk("add_c2_wb", wb.valid, 0);
        $display("[TB] add result=0x00001234");

        do_store("sb", BYTE, 32'h0000_0103, 32'h0000_00AB, 3, 32'h0000_0100, 4'b1000, 32'hABAB_ABAB);
        do_store("sh", HALF, 32'h0000_0106, 32'h1234_BEEF, 1, 32'h0000_0104, 4'b1100, 32'hBEEF_BEEF);
        do_store("sw", WORD, 32'h0000_0040, 32'h1122_3344, 0, 32'h0000_0040, 4'b1111, 32'h1122_3344);

        do_load("lh",  HALF, 1'b0, 5'd5,  32'h0000_0102, 32'h8001_0000, 4'b1100, 32'hFFFF_8001, 1'b1);
        do_load("lhu", HALF, 1'b1, 5'd9,  32'h0000_0102, 32'h8001_0000, 4'b1100, 32'h0000_8001, 1'b1);
        do_load("lb",  BYTE, 1'b0, 5'd12, 32'h0000_0201, 32'h0000_AB00, 4'b0010, 32'hFFFF_FFAB, 1'b0);
        do_load("lbu", BYTE, 1'b1, 5'd12, 32'h0000_0201, 32'h0000_AB00, 4'b0010, 32'h0000_00AB, 1'b0);
        do_load("lw_x0", WORD, 1'b0, 5'd0, 32'h0000_0300, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 1'b0);

        // Misaligned word load never reaches memory
        exe = mk(1'b1, 1'b0, WORD, 1'b0, 5'd6, 32'h0000_0101, 32'h0);
        tick();
        exe = '0;
        @(negedge clk_i);
        chk("mis_stall", stall, 0);
        chk("mis_req",   dmem_bus.dmem_req_valid_o, 0);
        tick();
        @(negedge clk_i);
        chk("mis_wb_valid", wb.valid, 1);
        chk("mis_wb_flag",  wb.misaligned, 1);
        chk("mis_wb_regwr", wb.instr.reg_write, 0);
        chk("mis_stall2",   stall, 0);
        $display("[TB] lw misaligned addr=0x00000101");

        // Reset while a load waits for its response
        exe = mk(1'b1, 1'b0, WORD, 1'b0, 5'd5, 32'h0000_0400, 32'h0);
        dmem_bus.dmem_req_ready_i = 1'b1;
        tick();
        dmem_bus.dmem_req_ready_i = 1'b0;
        tick();
        @(negedge clk_i);
        chk("rw_wait_stall", stall, 1);
        chk("rw_wait_haz",   hazard, 1);
        rstn_i = 1'b0;
        exe    = '0;
        #1;
        chk("rw_rst_stall", stall, 0);
        chk("rw_rst_req",   dmem_bus.dmem_req_valid_o, 0);
        chk("rw_rst_haz",   hazard, 0);
        tick();
        rstn_i = 1'b1;
        dmem_bus.dmem_rsp_valid_i = 1'b1;
        dmem_bus.dmem_rsp_rdata_i = 32'h5555_AAAA;
        @(negedge clk_i);
        chk("rw_rsp_stall", stall, 0);
        chk("rw_rsp_wb",    wb.valid, 0);
        tick();
        dmem_bus.dmem_rsp_valid_i = 1'b0;
        @(negedge clk_i);
        chk("rw_post_wb", wb.valid, 0);
        exe = mk(1'b0, 1'b0, WORD, 1'b0, 5'd4, 32'h0000_0077, 32'h0);
        tick();
        exe = '0;
        tick();
        @(negedge clk_i);
        chk("rw_add_wb",     wb.valid, 1);
        chk("rw_add_result", wb.result, 32'h0000_0077);
        $display("[TB] reset in WAIT, then add result=0x00000077");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
